// File: rtl/softmax_row_stream.sv
// Row-wise streaming softmax: buffers one score row, takes a max-subtracted
// shift/linear exponential, then scales every element by a serial reciprocal.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mode                  0 = base-e, 1 = base-2; latched on the first beat of a row
//   in_valid/in_ready     input handshake, in_data = signed Q.FRAC_BITS score
//   out_valid/out_ready   output handshake, out_data = unsigned Q1.FRAC_BITS
//   out_last              marks the final beat of a row
//   busy                  low only when idle in LOAD with no beats captured
module softmax_row_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 14,
    parameter int ROW_LEN    = 64,
    parameter int LOG2E      = 23637
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy
);

    localparam int KW  = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam int EW  = FRAC_BITS + 1;
    localparam int SW  = FRAC_BITS + 1 + KW;
    localparam int DW1 = DATA_WIDTH + 1;
    localparam int TW  = 2 * DW1;
    localparam int QW  = FRAC_BITS + 2;
    localparam int CW  = $clog2(QW + 1);

    localparam logic [KW-1:0]        K_LAST  = KW'(ROW_LEN - 1);
    localparam logic [CW-1:0]        C_LAST  = CW'(QW - 1);
    localparam logic signed [DW1-1:0] LOG2E_S = DW1'(LOG2E);
    localparam logic signed [TW-1:0] F_S     = TW'(FRAC_BITS);
    localparam logic [2*EW-1:0]      ONE2    = (2*EW)'(1) << FRAC_BITS;
    // 2^(2F) / 2^QW: the part of the dividend above the QW quotient bits
    localparam logic [SW-1:0]        R_INIT  = SW'(1) << (FRAC_BITS - 2);

    typedef enum logic [1:0] {LOAD, EXP, DIV, OUT} state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0]        buf_q [ROW_LEN];
    logic [KW-1:0]                k_q;
    logic signed [DATA_WIDTH-1:0] m_q;
    logic                         mode_q;
    logic                         rdy_q;
    logic [SW-1:0]                s_q;
    logic [SW-1:0]                r_q;
    logic [EW-1:0]                q_q;
    logic [CW-1:0]                cnt_q;

    logic                  in_fire, out_fire, k_last;
    logic [DATA_WIDTH-1:0] buf_rd;

    assign in_ready  = rdy_q && (state_q == LOAD);
    assign out_valid = (state_q == OUT);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign k_last    = (k_q == K_LAST);
    assign buf_rd    = buf_q[k_q];
    assign busy      = !((state_q == LOAD) && (k_q == '0));
    assign out_last  = out_valid && k_last;

    // exponential of one element
    logic signed [DW1-1:0] d;
    logic signed [TW-1:0]  dx, lx, prod, t, n, neg_n;
    logic [FRAC_BITS-1:0]  f;
    logic [EW-1:0]         e;

    always_comb begin
        d     = $signed({buf_rd[DATA_WIDTH-1], buf_rd})
              - $signed({m_q[DATA_WIDTH-1], m_q});
        dx    = {{DW1{d[DW1-1]}}, d};
        lx    = {{DW1{LOG2E_S[DW1-1]}}, LOG2E_S};
        prod  = dx * lx;
        t     = mode_q ? dx : (prod >>> FRAC_BITS);
        n     = t >>> FRAC_BITS;
        neg_n = -n;
        f     = t[FRAC_BITS-1:0];
        e     = '0;
        if (neg_n <= F_S) begin
            e = {1'b1, f} >> neg_n;
        end
    end

    // one restoring-divider step
    logic [SW:0]   r2;
    logic          q_bit;
    logic [SW-1:0] r_nx;

    always_comb begin
        r2    = {r_q, 1'b0};
        q_bit = (r2 >= {1'b0, s_q});
        r_nx  = q_bit ? SW'(r2 - {1'b0, s_q}) : SW'(r2);
    end

    // output scaling with saturation at 1.0
    logic [2*EW-1:0] prod2, scaled;

    always_comb begin
        prod2  = {{EW{1'b0}}, buf_rd[EW-1:0]} * {{EW{1'b0}}, q_q};
        scaled = prod2 >> FRAC_BITS;
        if (scaled > ONE2) begin
            scaled = ONE2;
        end
        out_data = (state_q == OUT) ? DATA_WIDTH'(scaled) : '0;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD:    if (in_fire && k_last)  state_d = EXP;
            EXP:     if (k_last)             state_d = DIV;
            DIV:     if (cnt_q == C_LAST)    state_d = OUT;
            OUT:     if (out_fire && k_last) state_d = LOAD;
            default:                         state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            k_q     <= '0;
            m_q     <= '0;
            mode_q  <= 1'b0;
            rdy_q   <= 1'b0;
            s_q     <= '0;
            r_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            unique case (state_q)
                LOAD: begin
                    if (in_fire) begin
                        if (k_q == '0) begin
                            m_q    <= in_data;
                            mode_q <= mode;
                        end else if ($signed(in_data) > m_q) begin
                            m_q <= in_data;
                        end
                        k_q <= k_last ? '0 : k_q + KW'(1);
                        s_q <= '0;
                    end
                end
                EXP: begin
                    s_q <= s_q + SW'(e);
                    k_q <= k_last ? '0 : k_q + KW'(1);
                    if (k_last) begin
                        r_q   <= R_INIT;
                        q_q   <= '0;
                        cnt_q <= '0;
                    end
                end
                DIV: begin
                    r_q   <= r_nx;
                    q_q   <= {q_q[EW-2:0], q_bit};
                    cnt_q <= cnt_q + CW'(1);
                end
                OUT: begin
                    if (out_fire) begin
                        k_q <= k_last ? '0 : k_q + KW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // row buffer: scores during LOAD, overwritten in place by e_k during EXP
    always_ff @(posedge clk) begin
        if (in_fire) begin
            buf_q[k_q] <= in_data;
        end else if (state_q == EXP) begin
            buf_q[k_q] <= DATA_WIDTH'(e);
        end
    end

endmodule
